// File: rtl/uart_pkg.sv
// Shared UART definitions: frame size, default bit timing and receiver states.
package uart_pkg;
  localparam int UART_DATA_BITS   = 8;
  localparam int DEF_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;
endpackage

// File: rtl/uart_rx_if.sv
// Serial line plus byte-stream valid/ready and status signals of the UART receiver.
interface uart_rx_if;
  import uart_pkg::*;

  logic                      rx_serial;
  logic [UART_DATA_BITS-1:0] rx_data;
  logic                      rx_valid;
  logic                      rx_ready;
  logic                      rx_busy;
  logic                      frame_err;
  logic                      overrun;

  modport master (
    input  rx_serial, rx_ready,
    output rx_data, rx_valid, rx_busy, frame_err, overrun
  );

  modport slave (
    output rx_serial, rx_ready,
    input  rx_data, rx_valid, rx_busy, frame_err, overrun
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input, with selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, start-glitch rejection, framing/overrun flags,
// byte delivered on a valid/ready holding register.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.master bus
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  rx_state_t                 state, state_n;
  logic [CNT_W-1:0]          cnt, cnt_n;
  logic [2:0]                bit_idx, idx_n;
  logic [UART_DATA_BITS-1:0] shift, shift_n;
  logic                      rxs, deliver, ferr_n;

  // Idle line is high, so the synchroniser resets to 1 to avoid a false start.
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(bus.rx_serial), .q(rxs));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= idx_n;
      shift   <= shift_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = bit_idx;
    shift_n = shift;
    deliver = 1'b0;
    ferr_n  = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        if (!rxs) state_n = START;
      end
      START: if (cnt == HALF_M1) begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = rxs ? IDLE : DATA;
      end
      DATA: if (cnt == FULL_M1) begin
        cnt_n            = '0;
        shift_n[bit_idx] = rxs;
        idx_n            = bit_idx + 3'd1;
        if (bit_idx == LAST_BIT) begin
          idx_n   = '0;
          state_n = STOP;
        end
      end
      // Stop is judged at its end-of-count point, half a bit before the nominal
      // stop end, which leaves room to catch a back-to-back start edge.
      STOP: if (cnt == FULL_M1) begin
        cnt_n = '0;
        if (rxs) begin
          deliver = 1'b1;
          state_n = IDLE;
        end else begin
          ferr_n  = 1'b1;
          state_n = BREAK;
        end
      end
      BREAK: begin
        cnt_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rx_data   <= '0;
      bus.rx_valid  <= 1'b0;
      bus.rx_busy   <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      bus.rx_busy   <= (state_n != IDLE);
      bus.frame_err <= ferr_n;
      bus.overrun   <= 1'b0;
      if (deliver) begin
        // A full holding register that is not being drained keeps the old byte.
        if (!bus.rx_valid || bus.rx_ready) begin
          bus.rx_data  <= shift;
          bus.rx_valid <= 1'b1;
        end else begin
          bus.overrun  <= 1'b1;
        end
      end else if (bus.rx_valid && bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames, directed corner sequences and random frames.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB  = DEF_CLKS_PER_BIT;
  // Cycles from D (first IDLE cycle seeing the low line) to rx_valid/flag visibility.
  localparam int DLAT = CPB/2 + 9*CPB + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_rx_if ifc();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (.clk(clk), .rst(rst), .bus(ifc));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    int         c;
    logic [7:0] d;
  } ev_t;

  ev_t  rise_q[$], chg_q[$], acc_q[$];
  int   fe_q[$], ov_q[$];
  logic pv = 1'b0;
  logic [7:0] pd = '0;

  always @(negedge clk) begin
    ev_t e;
    e.c = cyc;
    e.d = ifc.rx_data;
    if (!rst) begin
      if (ifc.rx_valid && !pv)                     rise_q.push_back(e);
      if (ifc.rx_valid && pv && ifc.rx_data != pd) chg_q.push_back(e);
      if (ifc.rx_valid && ifc.rx_ready)            acc_q.push_back(e);
      if (ifc.frame_err)                           fe_q.push_back(cyc);
      if (ifc.overrun)                             ov_q.push_back(cyc);
    end
    pv <= ifc.rx_valid;
    pd <= ifc.rx_data;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic clear_q();
    rise_q.delete(); chg_q.delete(); acc_q.delete(); fe_q.delete(); ov_q.delete();
  endtask

  // Drives one 8N1 frame; d returns the cycle the receiver first sees the start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int extra_low,
                            output int d);
    d = cyc + 2;
    ifc.rx_serial = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      ifc.rx_serial = b[i];
      repeat (CPB) tick();
    end
    ifc.rx_serial = stop;
    repeat (CPB) tick();
    if (!stop) begin
      repeat (extra_low) tick();
      ifc.rx_serial = 1'b1;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_nv;
    int         exp_nfe;
  } vec_t;

  vec_t vt[6];
  ev_t  exp_q[$];

  initial begin
    int d, d1, d2, d3;
    ev_t e;
    logic [7:0] b;
    int gap;

    vt[0] = '{8'hA5, 1'b1, 1, 0};
    vt[1] = '{8'h00, 1'b1, 1, 0};
    vt[2] = '{8'hFF, 1'b1, 1, 0};
    vt[3] = '{8'h3C, 1'b0, 0, 1};
    vt[4] = '{8'h01, 1'b1, 1, 0};
    vt[5] = '{8'h80, 1'b0, 0, 1};

    ifc.rx_serial = 1'b1;
    ifc.rx_ready  = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_data",  ifc.rx_data,   0);
    chk("rst_valid", ifc.rx_valid,  0);
    chk("rst_busy",  ifc.rx_busy,   0);
    chk("rst_ferr",  ifc.frame_err, 0);
    chk("rst_ovr",   ifc.overrun,   0);
    rst = 1'b0;
    repeat (5) tick();

    // Table of single frames, consumer always ready.
    for (int i = 0; i < 6; i++) begin
      clear_q();
      ifc.rx_ready = 1'b1;
      send_frame(vt[i].data, vt[i].stop, 0, d);
      repeat (20) tick();
      chk("tbl_nvalid", acc_q.size(), vt[i].exp_nv);
      if (vt[i].exp_nv == 1 && acc_q.size() == 1) begin
        chk("tbl_vcyc", acc_q[0].c, d + DLAT);
        chk("tbl_data", acc_q[0].d, vt[i].data);
      end
      chk("tbl_nferr", fe_q.size(), vt[i].exp_nfe);
      if (vt[i].exp_nfe == 1 && fe_q.size() == 1) chk("tbl_fecyc", fe_q[0], d + DLAT);
      chk("tbl_novr", ov_q.size(), 0);
    end

    // Short low glitch must be rejected at the mid start-bit sample.
    clear_q();
    ifc.rx_serial = 1'b0;
    d = cyc + 2;
    repeat (3) tick();
    ifc.rx_serial = 1'b1;
    tick_until(d + CPB/2);
    chk("glitch_busy_mid", ifc.rx_busy, 1);
    tick();
    chk("glitch_busy_after", ifc.rx_busy, 0);
    repeat (CPB*11) tick();
    chk("glitch_nvalid", rise_q.size() + acc_q.size(), 0);
    chk("glitch_nflags", fe_q.size() + ov_q.size(), 0);

    // Framing error with line held low, then recovery.
    clear_q();
    ifc.rx_ready = 1'b1;
    send_frame(8'h3C, 1'b0, 40, d);
    chk("brk_busy_held", ifc.rx_busy, 1);
    repeat (10) tick();
    chk("brk_busy_idle", ifc.rx_busy, 0);
    chk("brk_nferr", fe_q.size(), 1);
    if (fe_q.size() == 1) chk("brk_fecyc", fe_q[0], d + DLAT);
    chk("brk_nvalid", rise_q.size(), 0);
    send_frame(8'h55, 1'b1, 0, d);
    repeat (20) tick();
    chk("brk_next_n", acc_q.size(), 1);
    if (acc_q.size() == 1) begin
      chk("brk_next_data", acc_q[0].d, 8'h55);
      chk("brk_next_cyc",  acc_q[0].c, d + DLAT);
    end

    // Back-to-back frames with no consumer: second one overruns.
    clear_q();
    ifc.rx_ready = 1'b0;
    send_frame(8'h01, 1'b1, 0, d1);
    send_frame(8'hFF, 1'b1, 0, d2);
    repeat (20) tick();
    chk("b2b_d2_gap", d2 - d1, 10*CPB);
    chk("b2b_nrise", rise_q.size(), 1);
    if (rise_q.size() == 1) begin
      chk("b2b_rise_cyc",  rise_q[0].c, d1 + DLAT);
      chk("b2b_rise_data", rise_q[0].d, 8'h01);
    end
    chk("b2b_novr", ov_q.size(), 1);
    if (ov_q.size() == 1) chk("b2b_ovr_cyc", ov_q[0], d2 + DLAT);
    chk("b2b_nchg", chg_q.size(), 0);
    chk("b2b_hold_data",  ifc.rx_data,  8'h01);
    chk("b2b_hold_valid", ifc.rx_valid, 1);

    // Consumer accepts in the very cycle a new byte is delivered.
    clear_q();
    d3 = cyc + 2;
    fork
      send_frame(8'h80, 1'b1, 0, d);
      begin
        tick_until(d3 + DLAT - 1);
        ifc.rx_ready = 1'b1;
        tick();
        ifc.rx_ready = 1'b0;
      end
    join
    repeat (20) tick();
    chk("coin_nacc", acc_q.size(), 1);
    if (acc_q.size() == 1) begin
      chk("coin_acc_cyc",  acc_q[0].c, d3 + DLAT - 1);
      chk("coin_acc_data", acc_q[0].d, 8'h01);
    end
    chk("coin_nchg", chg_q.size(), 1);
    if (chg_q.size() == 1) begin
      chk("coin_chg_cyc",  chg_q[0].c, d3 + DLAT);
      chk("coin_chg_data", chg_q[0].d, 8'h80);
    end
    chk("coin_novr",  ov_q.size(),  0);
    chk("coin_valid", ifc.rx_valid, 1);
    chk("coin_data",  ifc.rx_data,  8'h80);
    ifc.rx_ready = 1'b1;
    tick();
    ifc.rx_ready = 1'b0;
    tick();
    chk("coin_drained", ifc.rx_valid, 0);

    // Reset in the middle of a data bit aborts the frame.
    clear_q();
    ifc.rx_ready = 1'b1;
    b = 8'hC3;
    ifc.rx_serial = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 4; i++) begin
      ifc.rx_serial = b[i];
      repeat (CPB) tick();
    end
    ifc.rx_serial = b[4];
    repeat (CPB/2) tick();
    rst = 1'b1;
    ifc.rx_serial = 1'b1;
    tick();
    chk("mrst_data",  ifc.rx_data,   0);
    chk("mrst_valid", ifc.rx_valid,  0);
    chk("mrst_busy",  ifc.rx_busy,   0);
    chk("mrst_ferr",  ifc.frame_err, 0);
    chk("mrst_ovr",   ifc.overrun,   0);
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    send_frame(8'h5A, 1'b1, 0, d);
    repeat (20) tick();
    chk("mrst_nacc", acc_q.size(), 1);
    if (acc_q.size() == 1) begin
      chk("mrst_acc_data", acc_q[0].d, 8'h5A);
      chk("mrst_acc_cyc",  acc_q[0].c, d + DLAT);
    end
    chk("mrst_nflags", fe_q.size() + ov_q.size(), 0);

    // Random bytes with random idle gaps (including none) against the frame-level model.
    clear_q();
    exp_q.delete();
    ifc.rx_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      b   = 8'($urandom);
      gap = (i % 3 == 0) ? 0 : int'($urandom_range(0, 40));
      send_frame(b, 1'b1, 0, d);
      e.c = d + DLAT;
      e.d = b;
      exp_q.push_back(e);
      repeat (gap) tick();
    end
    repeat (30) tick();
    chk("rnd_count", acc_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      chk("rnd_cyc",  acc_q[i].c, exp_q[i].c);
      chk("rnd_data", acc_q[i].d, exp_q[i].d);
    end
    chk("rnd_nflags", fe_q.size() + ov_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
